// File: rtl/mod_inv_sched.sv
// mod_inv_sched -- two-requester scheduler in front of one shared modular
// inverse core. Picks a requester round-robin, captures its operand, starts
// the core (or short-circuits a zero operand to an error result), waits for
// the core, and hands the result back with a done pulse to the owner.
//
// Optional build macro: MOD_INV_TIMEOUT_EN
//   defined   -> WAIT is guarded by a 16-bit watchdog; after TIMEOUT_CYCLES
//                WAIT cycles without core_done the request ends with err=1.
//   undefined -> no watchdog; WAIT holds until core_done.
//
// Ports
//   clk, reset        clock, synchronous active-low reset
//   req0/req1         level requests, held until the matching gnt pulse
//   op0/op1 [255:0]   operands, stable while the matching req is high
//   gnt0/gnt1         one-cycle accept pulse (operand captured)
//   done0/done1       one-cycle completion pulse for the owner
//   result [255:0]    shared result bus, valid while a done is high
//   err               qualifies done: zero operand or watchdog abort
//   core_start        one-cycle start strobe to the core
//   core_input_num    registered operand presented to the core
//   core_inverse      core result
//   core_done         core completion flag (honoured only in WAIT)
module mod_inv_sched #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0,
  input  logic         req1,
  input  logic [255:0] op0,
  input  logic [255:0] op1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         done0,
  output logic         done1,
  output logic [255:0] result,
  output logic         err,
  output logic         core_start,
  output logic [255:0] core_input_num,
  input  logic [255:0] core_inverse,
  input  logic         core_done
);

  // The watchdog counter is 16 bits wide, so the limit has to fit in it.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_chk
    $error("mod_inv_sched: TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_t;

  state_t       state;
  logic         owner;   // requester that owns the in-flight inversion
  logic         prio;    // requester favoured when both ask at once
  logic         win;
  logic [255:0] win_op;

`ifdef MOD_INV_TIMEOUT_EN
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES);
  logic [15:0] wd_cnt;
  logic [15:0] wd_nxt;
  always_comb wd_nxt = wd_cnt + 16'd1;
`endif

  // A lone requester always wins; a tie goes to the one not served last.
  always_comb begin
    win    = (req0 & req1) ? prio : req1;
    win_op = win ? op1 : op0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      owner          <= 1'b0;
      prio           <= 1'b0;
      gnt0           <= 1'b0;
      gnt1           <= 1'b0;
      done0          <= 1'b0;
      done1          <= 1'b0;
      result         <= '0;
      err            <= 1'b0;
      core_start     <= 1'b0;
      core_input_num <= '0;
`ifdef MOD_INV_TIMEOUT_EN
      wd_cnt         <= '0;
`endif
    end else begin
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      core_start <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            owner          <= win;
            prio           <= ~win;
            gnt0           <= ~win;
            gnt1           <= win;
            core_input_num <= win_op;
            // Start is registered here so it is high exactly during ISSUE,
            // and only when the captured operand is nonzero.
            core_start     <= (win_op != '0);
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          if (core_input_num == '0) begin
            // Zero has no inverse: skip the core entirely.
            result <= '0;
            err    <= 1'b1;
            done0  <= ~owner;
            done1  <= owner;
            state  <= DELIVER;
          end else begin
`ifdef MOD_INV_TIMEOUT_EN
            wd_cnt <= '0;
`endif
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (core_done) begin
            result <= core_inverse;
            err    <= 1'b0;
            done0  <= ~owner;
            done1  <= owner;
            state  <= DELIVER;
          end
`ifdef MOD_INV_TIMEOUT_EN
          else if (wd_nxt == TO_LIM) begin
            result <= '0;
            err    <= 1'b1;
            done0  <= ~owner;
            done1  <= owner;
            state  <= DELIVER;
          end else begin
            wd_cnt <= wd_nxt;
          end
`endif
        end
        DELIVER: state <= IDLE;  // done pulse is high during this cycle
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mod_inv_sched.md
MOD_INV_SCHED -- requirements
Module: mod_inv_sched

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 4096, core-done watchdog limit in clk cycles (used only with MOD_INV_TIMEOUT_EN).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 req0 / req1  input  1 each  requester 0/1 asks for an inversion; level, held until its gnt pulse.
REQ-005 op0 / op1  input  256 each  operand of requester 0/1; stable while its req is high.
REQ-006 gnt0 / gnt1  output  1 each  one-cycle pulse: request accepted, operand captured.
REQ-007 done0 / done1  output  1 each  one-cycle pulse: result for that requester valid this cycle.
REQ-008 result  output  256  shared inverse bus; valid only while done0 or done1 is high.
REQ-009 err  output  1  qualifies done: operand zero, or watchdog abort.
REQ-010 core_start  output  1  start strobe to the shared mod_inv core.
REQ-011 core_input_num  output  256  operand to the core; registered, held from ISSUE until return to IDLE.
REQ-012 core_inverse  input  256  core result.
REQ-013 core_done  input  1  core completion flag.

Function
REQ-014 FSM states: IDLE, ISSUE, WAIT, DELIVER; one-hot or binary encoding is free.
REQ-015 IDLE with at least one req high: select a winner, latch its op into an operand register, record owner, pulse its gnt the next cycle, and go to ISSUE.
REQ-016 Arbitration is round-robin: with both reqs high, the winner is the requester not served last; after reset, requester 0 has priority.
REQ-017 ISSUE with operand nonzero: core_start=1 for exactly this one cycle; next state WAIT.
REQ-018 ISSUE with operand zero: no core_start; latch result=0 and err=1; next state DELIVER.
REQ-019 WAIT: on core_done=1, latch core_inverse into result and err=0; next state DELIVER. core_done outside WAIT is ignored.
REQ-020 DELIVER: pulse done of the recorded owner for one cycle; next state IDLE.
REQ-021 Minimum latency, nonzero operand: req sampled at cycle t, gnt at t+1, core_start at t+1, done at (core_done cycle)+1.
REQ-022 Zero operand latency: req at t, done with err=1 at t+2.
REQ-023 Requests arriving outside IDLE are held by the requester and not lost; at most one inversion is in flight.
REQ-024 A req still high in the cycle after its gnt counts as a new request.
REQ-025 gnt0/gnt1 never both high; done0/done1 never both high; core_start never high outside ISSUE.

Reset
REQ-026 reset=0 at a rising edge: state=IDLE, round-robin pointer favours requester 0, and all outputs are 0 (gnt*, done*, result, err, core_start, core_input_num).
REQ-027 Reset mid-operation abandons the in-flight inversion; no done is issued for it; a core_done arriving later in IDLE is ignored.

Configuration
REQ-028 Macro MOD_INV_TIMEOUT_EN defined: a 16-bit counter clears on entry to WAIT and increments each WAIT cycle. When it reaches TIMEOUT_CYCLES without core_done, the block latches result=0 and err=1 and goes to DELIVER.
REQ-029 MOD_INV_TIMEOUT_EN undefined: no counter is built; WAIT waits indefinitely for core_done.

Verification
REQ-030 Bench uses a core stub that asserts core_done 20 cycles after core_start and returns a fixed value.
REQ-031 Single req0, op0=256'h3, stub returns 256'h7FFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF7FFFFE18 -> gnt0 one cycle after req, one core_start pulse, done0 with that result and err=0, done1 stays 0.
REQ-032 req0 and req1 high together from reset -> requester 0 served first and requester 1 second; repeating both -> order alternates 1 then 0.
REQ-033 op1=0 -> no core_start, done1 with result=0 and err=1 exactly two cycles after req1 is sampled.
REQ-034 reset pulled low 5 cycles into WAIT, then a stub core_done -> no done pulse; all outputs 0; next request is served normally.
REQ-035 MOD_INV_TIMEOUT_EN defined, TIMEOUT_CYCLES=64, stub never asserts done -> done0 with err=1 and result=0 after 64 WAIT cycles. Undefined -> no done after 1000 cycles.
